fetch_unit: RTL
===============

# fetch_unit

Parametrised instruction-fetch stage for the mips32 pipeline. It replaces the single-mode fetch with a two-mode unit: a code mode that writes a program into local instruction memory and an execute mode that fetches from it. Execute mode supports stall, branch redirect with bubble insertion, and halt detection. It sits ahead of the IF/ID pipeline register and is driven by the execute stage's branch outputs and the hazard logic's stall.

## Interface
Parameters:
- XLEN, 32, datapath, PC and instruction width
- IMEM_DEPTH, 1024, instruction memory depth in words; must be a power of two
- RESET_PC, 0, word address loaded into PC on reset and on each entry to RUN
- HLT_OP, 6'b111111, opcode (IR[XLEN-1:XLEN-6]) that halts fetch
- Derived localparam AW = $clog2(IMEM_DEPTH)

Ports:
- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  reset; synchronous and active-high
- mode  in  1  0 = code (program load), 1 = execute
- prog_we  in  1  instruction-memory write strobe; honoured only in LOAD
- prog_addr  in  AW  write word address
- prog_data  in  XLEN  instruction word to write
- stall  in  1  hold fetch; outputs and PC frozen
- redirect  in  1  taken branch from execute (sel)
- redirect_pc  in  XLEN  branch target word address
- if_valid  out  1  if_ir/if_pc/if_npc carry a live instruction
- if_ir  out  XLEN  fetched instruction
- if_pc  out  XLEN  address of if_ir
- if_npc  out  XLEN  if_pc + 1
- halted  out  1  high while in HALT
- fetch_cnt  out  XLEN  count of valid instructions issued since entering RUN

## Operation
- PC is a word address, XLEN wide. The memory index is PC[AW-1:0], so fetch wraps modulo IMEM_DEPTH. if_npc is the full XLEN sum and is not wrapped.
- States:
  - LOAD (reset state): prog_we writes mem[prog_addr] <= prog_data. No fetch; if_valid = 0.
  - RUN: normal fetch.
  - HALT: fetch stopped; halted = 1.
- Transitions:
  - LOAD -> RUN when mode = 1. Same edge: PC <= RESET_PC, fetch_cnt <= 0. The first fetch happens on the next edge.
  - RUN -> HALT on the edge that issues an instruction whose opcode equals HLT_OP. The HLT itself is issued with if_valid = 1.
  - HALT -> RUN on redirect = 1. An older branch squashes the HLT: PC <= redirect_pc, if_valid <= 0.
  - RUN or HALT -> LOAD when mode = 0. if_valid <= 0 and halted <= 0. PC and memory are retained.
- RUN per edge, in priority order:
  1. redirect: PC <= redirect_pc, if_valid <= 0 (one bubble), other outputs hold. Redirect beats stall.
  2. stall: everything holds, including if_valid and fetch_cnt.
  3. Otherwise issue:
     - if_ir <= mem[PC[AW-1:0]], if_pc <= PC, if_npc <= PC + 1
     - if_valid <= 1, PC <= PC + 1, fetch_cnt <= fetch_cnt + 1 (wraps at 2^XLEN)
- HALT: stall is ignored. if_valid <= 0 on the edge after the HLT issues and stays 0.
- prog_we outside LOAD is ignored. Memory is not cleared by rst.

## Timing
- Reset values:
  - state = LOAD, PC = RESET_PC
  - if_valid = 0, if_ir = 0, if_pc = 0, if_npc = 0
  - halted = 0, fetch_cnt = 0
- Reset mid-operation returns to LOAD on that edge. Memory contents survive.
- Fetch latency is 1 cycle: the PC presented at an edge appears as if_pc/if_ir after that edge.
- Redirect to first target instruction: 2 edges. Edge 1 loads PC and drives the bubble; edge 2 puts the target on if_ir.
- Redirect and stall on the same edge: redirect wins.
- HLT and redirect on the same issuing edge: redirect wins, so no HLT is issued and HALT is not entered.
- Writes are synchronous: a word written at edge N is fetchable from edge N+1.
- mode switching 0 -> 1 -> 0 -> 1 restarts at RESET_PC each time with fetch_cnt = 0.

## Test plan
- Load and run: with mode = 0, write mem[0..3] = 32'h0000_0001..4 and mem[4] = HLT; then set mode = 1. Required:
  - if_ir is 1, 2, 3, 4, HLT on consecutive cycles, with if_pc = 0..4 and if_npc = 1..5.
  - halted = 1 after the HLT issues; fetch_cnt = 5; if_valid = 0 thereafter.
- Stall: assert stall for 3 cycles while if_pc = 2. Required: if_pc, if_ir, if_valid and fetch_cnt hold for 3 cycles, then if_pc = 3 follows.
- Redirect: pulse redirect with redirect_pc = 10 while if_pc = 1. Required: next cycle if_valid = 0; the cycle after, if_pc = 10 and if_ir = mem[10]. Repeat with stall = 1 on the same edge: identical result.
- HALT recovery: after halted = 1, pulse redirect with redirect_pc = 0. Required: halted = 0, one bubble, then if_pc = 0.
- Wrap: with IMEM_DEPTH = 16 and redirect_pc = 15, run 2 fetches. Required:
  - if_pc = 15, then 16, with if_ir = mem[15], then mem[0].
  - if_npc = 16, then 17.
- Reset mid-run and write gating:
  - Assert rst while in RUN at if_pc = 7. Required: state returns to LOAD, if_valid = 0, fetch_cnt = 0, and memory is intact on reload.
  - Assert prog_we while in RUN. Required: no write happens (memory readback unchanged).

Source files
------------

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - program-load, control and fetch-output bundle for fetch_unit
interface fetch_unit_if #(
    parameter int XLEN = 32,
    parameter int AW   = 10
);
    logic            mode;
    logic            prog_we;
    logic [AW-1:0]   prog_addr;
    logic [XLEN-1:0] prog_data;
    logic            stall;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            if_valid;
    logic [XLEN-1:0] if_ir;
    logic [XLEN-1:0] if_pc;
    logic [XLEN-1:0] if_npc;
    logic            halted;
    logic [XLEN-1:0] fetch_cnt;

    modport master (
        output mode, prog_we, prog_addr, prog_data, stall, redirect, redirect_pc,
        input  if_valid, if_ir, if_pc, if_npc, halted, fetch_cnt
    );

    modport slave (
        input  mode, prog_we, prog_addr, prog_data, stall, redirect, redirect_pc,
        output if_valid, if_ir, if_pc, if_npc, halted, fetch_cnt
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - two-mode instruction fetch stage with local instruction memory
module fetch_unit #(
    parameter int              XLEN       = 32,
    parameter int              IMEM_DEPTH = 1024,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter logic [5:0]      HLT_OP     = 6'b111111
) (
    input logic         clk,
    input logic         rst,
    fetch_unit_if.slave bus
);
    localparam int AW = $clog2(IMEM_DEPTH);
    localparam logic [XLEN-1:0] ONE = XLEN'(1);

    typedef enum logic [1:0] {S_LOAD, S_RUN, S_HALT} state_t;

    state_t          state, state_next;
    logic [XLEN-1:0] mem [IMEM_DEPTH];
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] fetch_word;
    logic            fetch_is_hlt;
    logic            issue;
    logic            valid_q;
    logic [XLEN-1:0] ir_q, pc_q, npc_q, cnt_q;

    assign fetch_word   = mem[pc[AW-1:0]];
    assign fetch_is_hlt = (fetch_word[XLEN-1 -: 6] == HLT_OP);
    assign issue        = (state == S_RUN) && bus.mode && !bus.redirect && !bus.stall;

    always_ff @(posedge clk) begin
        if (rst) state <= S_LOAD;
        else     state <= state_next;
    end

    // mode = 0 outranks everything so the loader can always reclaim the memory
    always_comb begin
        state_next = state;
        case (state)
            S_LOAD: if (bus.mode) state_next = S_RUN;
            S_RUN: begin
                if (!bus.mode)         state_next = S_LOAD;
                else if (issue && fetch_is_hlt) state_next = S_HALT;
            end
            S_HALT: begin
                if (!bus.mode)         state_next = S_LOAD;
                else if (bus.redirect) state_next = S_RUN;
            end
            default: state_next = S_LOAD;
        endcase
    end

    // Memory is deliberately outside the reset domain so a program survives rst
    always_ff @(posedge clk) begin
        if (state == S_LOAD && bus.prog_we) mem[bus.prog_addr] <= bus.prog_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= RESET_PC;
            valid_q <= 1'b0;
            ir_q    <= '0;
            pc_q    <= '0;
            npc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state)
                S_LOAD: begin
                    valid_q <= 1'b0;
                    if (bus.mode) begin
                        pc    <= RESET_PC;
                        cnt_q <= '0;
                    end
                end
                S_RUN, S_HALT: begin
                    if (!bus.mode) begin
                        valid_q <= 1'b0;
                    end else if (bus.redirect) begin
                        pc      <= bus.redirect_pc;
                        valid_q <= 1'b0;
                    end else if (issue) begin
                        ir_q    <= fetch_word;
                        pc_q    <= pc;
                        npc_q   <= pc + ONE;
                        valid_q <= 1'b1;
                        pc      <= pc + ONE;
                        cnt_q   <= cnt_q + ONE;
                    end else if (state == S_HALT) begin
                        valid_q <= 1'b0;
                    end
                end
                default: valid_q <= 1'b0;
            endcase
        end
    end

    assign bus.if_valid  = valid_q;
    assign bus.if_ir     = ir_q;
    assign bus.if_pc     = pc_q;
    assign bus.if_npc    = npc_q;
    assign bus.halted    = (state == S_HALT);
    assign bus.fetch_cnt = cnt_q;
endmodule
